// File: rtl/clarvi_mem_arbiter_pkg.sv
// Shared types for the Clarvi memory arbiter: the owner tag carried by each
// outstanding read, plus a pointer-width helper for the tag FIFO.
package clarvi_mem_arbiter_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_MAIN  = 1'b1
    } mem_owner_t;

    // A depth-1 FIFO still needs a 1-bit pointer so the vectors stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/clarvi_mem_arbiter_tag.sv
// Tag FIFO remembering which port issued each outstanding read, so returning
// data can be steered back to it. Depth need not be a power of two.
module clarvi_tag_fifo
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  mem_owner_t in,
    output mem_owner_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    mem_owner_t       slot_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A pop frees its slot in the same cycle, so a push into a full FIFO is
    // legal whenever it is paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = slot_reg[rd_ptr_reg];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Tag storage; contents are only meaningful while occupied, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) slot_reg[wr_ptr_reg] <= in;
    end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Shares one pipelined Avalon-MM master between the Clarvi fetch port and the
// load/store port. Selection and acceptance are combinational; read returns
// are steered by a tag FIFO of outstanding read owners.
module clarvi_mem_arbiter
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 2,
    parameter int FAIR_LIMIT  = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   instr_address,
    input  logic                    instr_read,
    output logic                    instr_wait,
    output logic [DATA_WIDTH-1:0]   instr_read_data,
    output logic                    instr_read_data_valid,
    input  logic [ADDR_WIDTH-1:0]   main_address,
    input  logic                    main_read,
    input  logic                    main_write,
    input  logic [DATA_WIDTH/8-1:0] main_byte_enable,
    input  logic [DATA_WIDTH-1:0]   main_write_data,
    output logic                    main_wait,
    output logic [DATA_WIDTH-1:0]   main_read_data,
    output logic                    main_read_data_valid,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic                    mem_wait,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    input  logic                    mem_read_data_valid,
    output logic                    protocol_error
);

    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

    logic              lock_valid_reg;
    mem_owner_t        lock_owner_reg;
    logic [FAIR_W-1:0] fair_cnt_reg;
    logic              protocol_error_reg;

    logic       main_req;
    logic       locked_req;
    logic       lock_dropped;
    logic       sel_valid;
    mem_owner_t sel_owner;
    logic       sel_is_read;
    logic       sel_is_write;
    logic       driven;
    logic       accepted;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    mem_owner_t fifo_head;

    // A simultaneous read+write from main is treated as a write.
    assign main_req     = main_read || main_write;
    assign locked_req   = (lock_owner_reg == OWNER_INSTR) ? instr_read : main_req;
    assign lock_dropped = lock_valid_reg && !locked_req;

    // Owner selection: a waited command keeps the bus, then sole requester,
    // then main wins contention unless fetch has been starved FAIR_LIMIT times.
    always_comb begin
        sel_valid = instr_read || main_req;
        sel_owner = OWNER_MAIN;
        if (lock_valid_reg && locked_req)
            sel_owner = lock_owner_reg;
        else if (instr_read && !main_req)
            sel_owner = OWNER_INSTR;
        else if (!instr_read && main_req)
            sel_owner = OWNER_MAIN;
        else if (fair_cnt_reg == FAIR_W'(FAIR_LIMIT))
            sel_owner = OWNER_INSTR;
    end

    assign sel_is_read  = sel_valid && ((sel_owner == OWNER_INSTR) || !main_write);
    assign sel_is_write = sel_valid && (sel_owner == OWNER_MAIN) && main_write;

    // Reads stall only when every tag slot is taken and none frees this cycle;
    // the bus is kept quiet while reset is held.
    assign mem_read  = reset_n && sel_is_read && !(fifo_full && !fifo_pop);
    assign mem_write = reset_n && sel_is_write;
    assign driven    = mem_read || mem_write;
    assign accepted  = driven && !mem_wait;

    assign mem_address     = (sel_owner == OWNER_INSTR) ? instr_address : main_address;
    assign mem_byte_enable = (sel_owner == OWNER_INSTR) ? '1 : main_byte_enable;
    assign mem_write_data  = main_write_data;

    assign instr_wait = instr_read && !(accepted && (sel_owner == OWNER_INSTR));
    assign main_wait  = main_req && !(accepted && (sel_owner == OWNER_MAIN));

    assign fifo_push = accepted && mem_read;
    assign fifo_pop  = mem_read_data_valid && !fifo_empty;

    assign instr_read_data       = mem_read_data;
    assign main_read_data        = mem_read_data;
    assign instr_read_data_valid = fifo_pop && (fifo_head == OWNER_INSTR);
    assign main_read_data_valid  = fifo_pop && (fifo_head == OWNER_MAIN);
    assign protocol_error        = protocol_error_reg;

    clarvi_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .in      (sel_owner),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Lock, fairness counter and sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_valid_reg     <= 1'b0;
            lock_owner_reg     <= OWNER_INSTR;
            fair_cnt_reg       <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            if (driven && mem_wait) begin
                lock_valid_reg <= 1'b1;
                lock_owner_reg <= sel_owner;
            end else if (accepted || lock_dropped) begin
                lock_valid_reg <= 1'b0;
            end

            if (!instr_read || (accepted && (sel_owner == OWNER_INSTR)))
                fair_cnt_reg <= '0;
            else if (accepted && (sel_owner == OWNER_MAIN) &&
                     (fair_cnt_reg != FAIR_W'(FAIR_LIMIT)))
                fair_cnt_reg <= fair_cnt_reg + FAIR_W'(1);

            if (lock_dropped || (main_read && main_write) ||
                (mem_read_data_valid && fifo_empty))
                protocol_error_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Self-checking bench for clarvi_mem_arbiter: directed scenarios followed by
// randomized legal traffic against a behavioural reference model.
module tb_clarvi_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXP = 2;
    localparam int FL   = 4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] instr_address;
    logic          instr_read;
    logic          instr_wait;
    logic [DW-1:0] instr_read_data;
    logic          instr_read_data_valid;
    logic [AW-1:0] main_address;
    logic          main_read;
    logic          main_write;
    logic [BW-1:0] main_byte_enable;
    logic [DW-1:0] main_write_data;
    logic          main_wait;
    logic [DW-1:0] main_read_data;
    logic          main_read_data_valid;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [BW-1:0] mem_byte_enable;
    logic [DW-1:0] mem_write_data;
    logic          mem_wait;
    logic [DW-1:0] mem_read_data;
    logic          mem_read_data_valid;
    logic          protocol_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    clarvi_mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_PENDING (MAXP),
        .FAIR_LIMIT  (FL)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .instr_address         (instr_address),
        .instr_read            (instr_read),
        .instr_wait            (instr_wait),
        .instr_read_data       (instr_read_data),
        .instr_read_data_valid (instr_read_data_valid),
        .main_address          (main_address),
        .main_read             (main_read),
        .main_write            (main_write),
        .main_byte_enable      (main_byte_enable),
        .main_write_data       (main_write_data),
        .main_wait             (main_wait),
        .main_read_data        (main_read_data),
        .main_read_data_valid  (main_read_data_valid),
        .mem_address           (mem_address),
        .mem_read              (mem_read),
        .mem_write             (mem_write),
        .mem_byte_enable       (mem_byte_enable),
        .mem_write_data        (mem_write_data),
        .mem_wait              (mem_wait),
        .mem_read_data         (mem_read_data),
        .mem_read_data_valid   (mem_read_data_valid),
        .protocol_error        (protocol_error)
    );

    task automatic idle_inputs();
        instr_address       = '0;
        instr_read          = 1'b0;
        main_address        = '0;
        main_read           = 1'b0;
        main_write          = 1'b0;
        main_byte_enable    = '0;
        main_write_data     = '0;
        mem_wait            = 1'b0;
        mem_read_data       = '0;
        mem_read_data_valid = 1'b0;
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        instr_read = 1'b1;
        main_write = 1'b1;
        mem_read_data_valid = 1'b1;
        #2;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got rd=%b wr=%b required 0 0", mem_read, mem_write);
        end
        checks++;
        if (instr_read_data_valid !== 1'b0 || main_read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got %b %b required 0 0", instr_read_data_valid, main_read_data_valid);
        end
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error got %b required 0", protocol_error);
        end
        do_reset();
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b0 || instr_wait !== 1'b0 || main_wait !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got err=%b iw=%b mw=%b required 0 0 0", protocol_error, instr_wait, main_wait);
        end
        $display("test_reset done");
        step();
    endtask

    task automatic test_fetch_only();
        logic [DW-1:0] d;
        d = $urandom;
        instr_read = 1'b1;
        instr_address = 32'h100;
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h100 ||
            mem_byte_enable !== {BW{1'b1}} || instr_wait !== 1'b0) begin
            errors++;
            $display("FAIL fetch_issue got rd=%b wr=%b addr=%h be=%h iw=%b required 1 0 100 f 0",
                     mem_read, mem_write, mem_address, mem_byte_enable, instr_wait);
        end
        step();
        instr_read = 1'b0;
        step();
        mem_read_data_valid = 1'b1;
        mem_read_data = d;
        @(negedge clock);
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== d || main_read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_return got iv=%b data=%h mv=%b required 1 %h 0",
                     instr_read_data_valid, instr_read_data, main_read_data_valid, d);
        end
        $display("fetch addr 100 data %h", d);
        step();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (instr_read_data_valid !== 1'b0 || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after got iv=%b err=%b required 0 0", instr_read_data_valid, protocol_error);
        end
        step();
    endtask

    task automatic test_contention();
        int exp_q[$];
        int exp_grant;
        int got_grant;
        int ret_owner;
        logic [DW-1:0] rdata;
        instr_read = 1'b1;
        main_read = 1'b1;
        instr_address = 32'h200;
        main_address = 32'h3000;
        for (int k = 0; k < 10; k++) begin
            ret_owner = -1;
            rdata = $urandom;
            mem_read_data = rdata;
            mem_read_data_valid = 1'b0;
            if (exp_q.size() > 0) begin
                ret_owner = exp_q.pop_front();
                mem_read_data_valid = 1'b1;
            end
            // Every (FL+1)-th contested grant goes to fetch.
            exp_grant = (k % (FL + 1) == FL) ? 0 : 1;
            @(negedge clock);
            got_grant = !instr_wait ? 0 : (!main_wait ? 1 : -1);
            checks++;
            if (got_grant !== exp_grant) begin
                errors++;
                $display("FAIL contention_grant%0d got %0d required %0d", k, got_grant, exp_grant);
            end
            checks++;
            if (mem_address !== (exp_grant == 0 ? 32'h200 : 32'h3000)) begin
                errors++;
                $display("FAIL contention_addr%0d got %h", k, mem_address);
            end
            if (ret_owner >= 0) begin
                checks++;
                if (instr_read_data_valid !== (ret_owner == 0) || main_read_data_valid !== (ret_owner == 1) ||
                    (ret_owner == 0 ? instr_read_data : main_read_data) !== rdata) begin
                    errors++;
                    $display("FAIL contention_return%0d got iv=%b mv=%b required owner %0d data %h",
                             k, instr_read_data_valid, main_read_data_valid, ret_owner, rdata);
                end
            end
            $display("contention grant %0d to %s", k, exp_grant == 0 ? "instr" : "main");
            exp_q.push_back(exp_grant);
            step();
        end
        instr_read = 1'b0;
        main_read = 1'b0;
        ret_owner = exp_q.pop_front();
        mem_read_data_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (instr_read_data_valid !== (ret_owner == 0) || main_read_data_valid !== (ret_owner == 1)) begin
            errors++;
            $display("FAIL contention_last got iv=%b mv=%b required owner %0d",
                     instr_read_data_valid, main_read_data_valid, ret_owner);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_lock();
        logic [DW-1:0] wd;
        wd = $urandom;
        main_write = 1'b1;
        main_address = 32'h4440;
        main_write_data = wd;
        main_byte_enable = 4'h3;
        instr_address = 32'h500;
        mem_wait = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) instr_read = 1'b1;
            if (c == 3) mem_wait = 1'b0;
            @(negedge clock);
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h4440 ||
                mem_write_data !== wd || mem_byte_enable !== 4'h3) begin
                errors++;
                $display("FAIL lock_hold%0d got wr=%b rd=%b addr=%h data=%h be=%h", c,
                         mem_write, mem_read, mem_address, mem_write_data, mem_byte_enable);
            end
            checks++;
            if (instr_wait !== (c >= 1) || main_wait !== (c != 3)) begin
                errors++;
                $display("FAIL lock_wait%0d got iw=%b mw=%b required %b %b", c,
                         instr_wait, main_wait, c >= 1, c != 3);
            end
            step();
        end
        main_write = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h500 || instr_wait !== 1'b0) begin
            errors++;
            $display("FAIL lock_after got rd=%b addr=%h iw=%b required 1 500 0", mem_read, mem_address, instr_wait);
        end
        $display("lock store %h then fetch 500", wd);
        step();
        instr_read = 1'b0;
        mem_read_data_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (instr_read_data_valid !== 1'b1 || main_read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_return got iv=%b mv=%b required 1 0", instr_read_data_valid, main_read_data_valid);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        instr_read = 1'b1;
        instr_address = 32'h600;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_read_data_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (mem_read !== (c != 2) || instr_wait !== (c == 2)) begin
                errors++;
                $display("FAIL fifo_issue%0d got rd=%b iw=%b required %b %b", c,
                         mem_read, instr_wait, c != 2, c == 2);
            end
            if (c == 3) begin
                checks++;
                if (instr_read_data_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL fifo_pushpop_valid got %b required 1", instr_read_data_valid);
                end
            end
            step();
        end
        instr_read = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mem_read_data_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (instr_read_data_valid !== 1'b1) begin
                errors++;
                $display("FAIL fifo_drain%0d got %b required 1", c, instr_read_data_valid);
            end
            step();
        end
        idle_inputs();
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL fifo_error got %b required 0", protocol_error);
        end
        $display("fifo full stall and push/pop checked");
        step();
    endtask

    task automatic test_errors();
        mem_read_data_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (instr_read_data_valid !== 1'b0 || main_read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_empty_valids got %b %b required 0 0", instr_read_data_valid, main_read_data_valid);
        end
        step();
        mem_read_data_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL err_empty_set got %b required 1", protocol_error);
        end
        repeat (3) step();
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b required 1", protocol_error);
        end
        do_reset();
        main_read = 1'b1;
        main_write = 1'b1;
        main_address = 32'h700;
        @(negedge clock);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || main_wait !== 1'b0 || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL err_rw_issue got wr=%b rd=%b mw=%b err=%b required 1 0 0 0",
                     mem_write, mem_read, main_wait, protocol_error);
        end
        step();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL err_rw_set got %b required 1", protocol_error);
        end
        $display("protocol error cases checked");
        do_reset();
    endtask

    task automatic test_reset_mid();
        instr_read = 1'b1;
        instr_address = 32'h800;
        repeat (2) step();
        reset_n = 1'b0;
        mem_read_data_valid = 1'b1;
        #2;
        checks++;
        if (mem_read !== 1'b0 || instr_read_data_valid !== 1'b0 || main_read_data_valid !== 1'b0 ||
            protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got rd=%b iv=%b mv=%b err=%b required 0 0 0 0",
                     mem_read, instr_read_data_valid, main_read_data_valid, protocol_error);
        end
        do_reset();
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release got %b required 0", protocol_error);
        end
        step();
        mem_read_data_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (instr_read_data_valid !== 1'b0 || main_read_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_late got %b %b required 0 0", instr_read_data_valid, main_read_data_valid);
        end
        step();
        mem_read_data_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL midreset_late_err got %b required 1", protocol_error);
        end
        $display("mid-operation reset checked");
        do_reset();
    endtask

    // Randomized legal traffic. Owners: 0 = instr, 1 = main.
    task automatic test_random();
        int  pend_q[$];
        bit  lk;
        int  lk_owner;
        int  fc;
        bit  i_req, m_req, m_wr;
        int  o;
        bit  any, is_rd, exp_rd, exp_wr, acc, vld;
        int  head;
        lk = 0; lk_owner = 0; fc = 0;
        i_req = 0; m_req = 0; m_wr = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!i_req && ($urandom_range(0, 9) < 6)) begin
                i_req = 1;
                instr_address = $urandom & 32'hffff_fffc;
            end
            if (!m_req && ($urandom_range(0, 9) < 5)) begin
                m_req = 1;
                m_wr = $urandom_range(0, 1);
                main_address = $urandom & 32'hffff_fffc;
                main_write_data = $urandom;
                main_byte_enable = BW'($urandom_range(1, (1 << BW) - 1));
            end
            instr_read = i_req;
            main_read = m_req && !m_wr;
            main_write = m_req && m_wr;
            mem_wait = ($urandom_range(0, 9) < 3);
            vld = (pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_read_data_valid = vld;
            mem_read_data = $urandom;

            if (lk && (lk_owner == 0 ? i_req : m_req)) o = lk_owner;
            else if (i_req && !m_req) o = 0;
            else if (m_req && !i_req) o = 1;
            else o = (fc == FL) ? 0 : 1;
            any = i_req || m_req;
            is_rd = any && (o == 0 || !m_wr);
            exp_rd = is_rd && (pend_q.size() < MAXP || vld);
            exp_wr = any && o == 1 && m_wr;
            acc = (exp_rd || exp_wr) && !mem_wait;
            head = vld ? pend_q[0] : -1;

            @(negedge clock);
            checks++;
            if (mem_read !== exp_rd || mem_write !== exp_wr) begin
                errors++;
                $display("FAIL rand_cmd%0d got rd=%b wr=%b required %b %b", cyc, mem_read, mem_write, exp_rd, exp_wr);
            end
            checks++;
            if (instr_wait !== (i_req && !(acc && o == 0)) || main_wait !== (m_req && !(acc && o == 1))) begin
                errors++;
                $display("FAIL rand_wait%0d got iw=%b mw=%b owner %0d acc %b", cyc, instr_wait, main_wait, o, acc);
            end
            if (exp_rd || exp_wr) begin
                checks++;
                if (mem_address !== (o == 0 ? instr_address : main_address) ||
                    mem_byte_enable !== (o == 0 ? {BW{1'b1}} : main_byte_enable) ||
                    (exp_wr && mem_write_data !== main_write_data)) begin
                    errors++;
                    $display("FAIL rand_payload%0d got addr=%h be=%h owner %0d", cyc, mem_address, mem_byte_enable, o);
                end
            end
            checks++;
            if (instr_read_data_valid !== (head == 0) || main_read_data_valid !== (head == 1) ||
                (vld && instr_read_data !== mem_read_data) || (vld && main_read_data !== mem_read_data)) begin
                errors++;
                $display("FAIL rand_return%0d got iv=%b mv=%b required head %0d", cyc,
                         instr_read_data_valid, main_read_data_valid, head);
            end
            checks++;
            if (protocol_error !== 1'b0) begin
                errors++;
                $display("FAIL rand_error%0d got %b required 0", cyc, protocol_error);
            end

            if (vld) void'(pend_q.pop_front());
            if (acc && exp_rd) pend_q.push_back(o);
            if ((exp_rd || exp_wr) && mem_wait) begin
                lk = 1;
                lk_owner = o;
            end else if (acc) begin
                lk = 0;
            end
            if (!i_req || (acc && o == 0)) fc = 0;
            else if (acc && o == 1 && fc < FL) fc++;
            if (acc && o == 0) i_req = 0;
            if (acc && o == 1) m_req = 0;
            step();
        end
        idle_inputs();
        while (pend_q.size() > 0) begin
            mem_read_data_valid = 1'b1;
            head = pend_q.pop_front();
            @(negedge clock);
            checks++;
            if (instr_read_data_valid !== (head == 0) || main_read_data_valid !== (head == 1)) begin
                errors++;
                $display("FAIL rand_drain got iv=%b mv=%b required head %0d",
                         instr_read_data_valid, main_read_data_valid, head);
            end
            step();
        end
        idle_inputs();
        $display("random traffic 2000 cycles done");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_contention();
        test_lock();
        test_fifo_full();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
